// File: rtl/simpsons_gate_conditioner.sv
// -----------------------------------------------------------------------------
// simpsons_gate_conditioner
//
// Input conditioning stage in front of the Bart/Homer gate sensor FSM. The two
// raw beam-break inputs are asynchronous and noisy. Each one is brought into
// the CLK domain through a two-flop synchroniser. A per-channel counter then
// debounces it, and the result is published on the clean 2-bit G bus.
//
// Around that bus the block also generates:
//   - one-cycle rise/fall strobes per channel, aligned with the G_CLEAN change;
//   - a per-channel stuck flag when a beam has been broken for too long;
//   - a sticky overlap error when both beams read broken together (G == 3).
//     The downstream FSM treats G == 3 as undefined.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a new synchronised level must hold (1..2^CNT_W-1)
//   STUCK_CYCLES     cycles G_CLEAN[i] may stay 1 before STUCK[i] (1..2^CNT_W-1)
//   CNT_W            width of the debounce and stuck counters
//
// Ports:
//   CLK          in   system clock, rising edge only
//   RESET_N      in   asynchronous active-low reset
//   G_RAW[1:0]   in   raw beam sensors (bit0 outer gate, bit1 inner gate)
//   CLR_ERR      in   synchronous clear of OVERLAP_ERR (a new overlap wins)
//   G_CLEAN[1:0] out  debounced sensor bus
//   RISE[1:0]    out  one-cycle pulse when G_CLEAN[i] goes 0->1
//   FALL[1:0]    out  one-cycle pulse when G_CLEAN[i] goes 1->0
//   STUCK[1:0]   out  G_CLEAN[i] has been 1 for at least STUCK_CYCLES cycles
//   OVERLAP_ERR  out  sticky: G_CLEAN has been 3
//
// Every output comes straight from a flop. No input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module simpsons_gate_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int STUCK_CYCLES    = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] G_RAW,
  input  logic       CLR_ERR,
  output logic [1:0] G_CLEAN,
  output logic [1:0] RISE,
  output logic [1:0] FALL,
  output logic [1:0] STUCK,
  output logic       OVERLAP_ERR
);

  // The debounce counter counts from 0. The last mismatching cycle before
  // the clean level flips is therefore DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_MAX  = CNT_W'(STUCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       s0_q, s0_d;            // first synchroniser stage
  logic [1:0]       s1_q, s1_d;            // second stage, only one used below
  logic [1:0]       g_clean_q, g_clean_d;
  logic [1:0]       rise_q, rise_d;
  logic [1:0]       fall_q, fall_d;
  logic [1:0]       stuck_q, stuck_d;
  logic             overlap_q, overlap_d;
  logic [CNT_W-1:0] dcnt_q [2];
  logic [CNT_W-1:0] dcnt_d [2];
  logic [CNT_W-1:0] scnt_q [2];
  logic [CNT_W-1:0] scnt_d [2];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    s0_d      = G_RAW;
    s1_d      = s0_q;
    g_clean_d = g_clean_q;
    rise_d    = 2'b00;
    fall_d    = 2'b00;
    stuck_d   = 2'b00;

    for (int i = 0; i < 2; i++) begin
      // Debounce. While the synchronised level disagrees with the clean
      // level, count the consecutive disagreeing cycles. When the levels
      // agree again, the count restarts from zero. This is what swallows
      // glitches.
      dcnt_d[i] = '0;
      if (s1_q[i] != g_clean_q[i]) begin
        if (dcnt_q[i] == DB_LAST) begin
          g_clean_d[i] = s1_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + CNT_ONE;
        end
      end

      // The strobes are registered alongside G_CLEAN, so they line up with
      // the cycle in which the new level first appears.
      rise_d[i] =  g_clean_d[i] & ~g_clean_q[i];
      fall_d[i] = ~g_clean_d[i] &  g_clean_q[i];

      // Stuck counter. It measures how long the registered clean bit has
      // been high, and it saturates instead of wrapping. STUCK is gated
      // by the current clean level, so the flag drops on the first edge
      // after the fall. It does not wait for the counter to clear.
      if (!g_clean_q[i]) begin
        scnt_d[i] = '0;
      end else if (scnt_q[i] == ST_MAX) begin
        scnt_d[i] = scnt_q[i];
      end else begin
        scnt_d[i] = scnt_q[i] + CNT_ONE;
      end
      stuck_d[i] = g_clean_q[i] && (scnt_q[i] == ST_MAX);
    end

    // Sticky overlap. A G == 3 observation sets the flag even when
    // CLR_ERR is high in the same cycle.
    overlap_d = (&g_clean_q) | (overlap_q & ~CLR_ERR);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s0_q      <= 2'b00;
      s1_q      <= 2'b00;
      g_clean_q <= 2'b00;
      rise_q    <= 2'b00;
      fall_q    <= 2'b00;
      stuck_q   <= 2'b00;
      overlap_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        dcnt_q[i] <= '0;
        scnt_q[i] <= '0;
      end
    end else begin
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      g_clean_q <= g_clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      stuck_q   <= stuck_d;
      overlap_q <= overlap_d;
      for (int i = 0; i < 2; i++) begin
        dcnt_q[i] <= dcnt_d[i];
        scnt_q[i] <= scnt_d[i];
      end
    end
  end

  assign G_CLEAN     = g_clean_q;
  assign RISE        = rise_q;
  assign FALL        = fall_q;
  assign STUCK       = stuck_q;
  assign OVERLAP_ERR = overlap_q;

endmodule
